// File: rtl/switch_debouncer.sv
// Eight-bit switch debouncer: each raw switch bit is synchronized, then it must disagree
// with its stable level for DEBOUNCE_CYCLES consecutive edges before the level updates.

module switch_debouncer_bit #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic stable_o,
    output logic changed_o
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d;
    logic             chg_q, chg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The counter only runs while the synchronized level disagrees with the stable level.
    // Any agreeing edge drops the run, so the count never wraps.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        chg_d    = 1'b0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d = sync2_q;
                chg_d    = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            chg_q    <= 1'b0;
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            chg_q    <= chg_d;
        end
    end

    assign stable_o  = stable_q;
    assign changed_o = chg_q;
endmodule

module switch_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] swt_raw,
    output logic [7:0] swt,
    output logic       swt_changed,
    output logic [7:0] changed_mask
);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

    for (genvar i = 0; i < 8; i++) begin : g_bit
        switch_debouncer_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_bit (
            .clk      (clk),
            .rst      (rst),
            .raw_i    (swt_raw[i]),
            .stable_o (swt[i]),
            .changed_o(changed_mask[i])
        );
    end

    assign swt_changed = |changed_mask;
endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: directed tables and sequences plus random traffic,
// all checked against a run-length model of the debounce rules.

module tb_switch_debouncer;
    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] swt_raw = 8'h00;
    logic [7:0] swt;
    logic       swt_changed;
    logic [7:0] changed_mask;

    int n_cmp = 0;
    int n_err = 0;

    switch_debouncer #(.DEBOUNCE_CYCLES(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .swt_raw     (swt_raw),
        .swt         (swt),
        .swt_changed (swt_changed),
        .changed_mask(changed_mask)
    );

    always #5 clk = ~clk;

    // Model: raw level seen two edges late, stable level flips after N consecutive disagreeing edges.
    logic [7:0] m_d1, m_d2, m_swt, m_mask;
    int         m_run [8];

    task automatic model_clear();
        m_d1 = 8'h00; m_d2 = 8'h00; m_swt = 8'h00; m_mask = 8'h00;
        for (int i = 0; i < 8; i++) m_run[i] = 0;
    endtask

    task automatic model_edge(input logic [7:0] raw);
        logic [7:0] seen;
        seen   = m_d2;
        m_mask = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (seen[i] != m_swt[i]) begin
                m_run[i] = m_run[i] + 1;
                if (m_run[i] == N) begin
                    m_swt[i]  = seen[i];
                    m_mask[i] = 1'b1;
                    m_run[i]  = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_d2 = m_d1;
        m_d1 = raw;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string name);
        chk({name, ".swt"}, swt, m_swt);
        chk({name, ".mask"}, changed_mask, m_mask);
        chk({name, ".chg"}, {7'd0, swt_changed}, {7'd0, |m_mask});
    endtask

    task automatic tick(input logic [7:0] raw, input string name);
        swt_raw = raw;
        @(posedge clk);
        model_edge(raw);
        #1;
        chk_model(name);
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        #1;
        model_clear();
        chk("rst.swt", swt, 8'h00);
        chk("rst.mask", changed_mask, 8'h00);
        chk("rst.chg", {7'd0, swt_changed}, 8'h00);
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic [7:0] raw;
        logic [7:0] exp_swt;
        logic [7:0] exp_mask;
    } vec_t;

    vec_t vecs [7];

    initial begin
        // Raw 00 -> 13 before edge 0: update lands after edge 5 only.
        vecs[0] = '{8'h13, 8'h00, 8'h00};
        vecs[1] = '{8'h13, 8'h00, 8'h00};
        vecs[2] = '{8'h13, 8'h00, 8'h00};
        vecs[3] = '{8'h13, 8'h00, 8'h00};
        vecs[4] = '{8'h13, 8'h00, 8'h00};
        vecs[5] = '{8'h13, 8'h13, 8'h13};
        vecs[6] = '{8'h13, 8'h13, 8'h00};

        model_clear();
        do_reset(2);

        for (int c = 0; c < 20; c++) begin
            tick(8'h00, "idle");
            chk("idle.swt", swt, 8'h00);
        end

        for (int v = 0; v < 7; v++) begin
            tick(vecs[v].raw, "tbl");
            chk("tbl.swt", swt, vecs[v].exp_swt);
            chk("tbl.mask", changed_mask, vecs[v].exp_mask);
            chk("tbl.chg", {7'd0, swt_changed}, {7'd0, |vecs[v].exp_mask});
        end
        repeat (4) tick(8'h13, "hold");

        // Three-cycle glitch on bit 6 is rejected.
        repeat (3) tick(8'h53, "glitch");
        for (int c = 0; c < 10; c++) begin
            tick(8'h13, "glitch");
            chk("glitch.swt", swt, 8'h13);
            chk("glitch.chg", {7'd0, swt_changed}, 8'h00);
        end

        // Bounce then hold: the count restarts from the final rising edge.
        tick(8'h53, "bounce");
        tick(8'h13, "bounce");
        for (int j = 0; j < 7; j++) begin
            tick(8'h53, "bounce");
            chk("bounce.swt", swt, (j < 5) ? 8'h13 : 8'h53);
            chk("bounce.mask", changed_mask, (j == 5) ? 8'h40 : 8'h00);
        end

        // Bits 0 and 7 change two edges apart: two separate pulses.
        for (int j = 0; j < 10; j++) begin
            tick((j < 2) ? 8'h52 : 8'hD2, "stagger");
            chk("stagger.mask", changed_mask,
                (j == 5) ? 8'h01 : (j == 7) ? 8'h80 : 8'h00);
            chk("stagger.chg", {7'd0, swt_changed}, {7'd0, (j == 5) || (j == 7)});
        end
        chk("stagger.swt", swt, 8'hD2);

        // Reset two edges into a qualifying count discards it; fresh count after release.
        tick(8'h19, "midrst");
        tick(8'h19, "midrst");
        do_reset(2);
        for (int j = 0; j < 8; j++) begin
            tick(8'h19, "postrst");
            chk("postrst.swt", swt, (j < 5) ? 8'h00 : 8'h19);
            chk("postrst.mask", changed_mask, (j == 5) ? 8'h19 : 8'h00);
        end

        // Random traffic: hold a pattern for 1..7 edges, flip random bits, rare resets.
        begin
            logic [7:0] r;
            r = 8'h19;
            for (int k = 0; k < 300; k++) begin
                int hold;
                if ($urandom_range(0, 3) == 0) r = r ^ 8'($urandom_range(0, 255));
                hold = $urandom_range(1, 7);
                for (int h = 0; h < hold; h++) tick(r, "rand");
                if ($urandom_range(0, 99) == 0) do_reset(1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/switch_debouncer.md
SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning the number of consecutive clock edges a synchronized input must disagree with its stable value before the stable value updates (legal range 2..2^24).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: the reset, asynchronous and active-high.
REQ-004 The block SHALL have port swt_raw, input, 8 bits: raw board switch levels, asynchronous to clk.
REQ-005 The block SHALL have port swt, output, 8 bits: the debounced switch bus, registered, which feeds the 3-bit adder/subtractor swt input directly.
REQ-006 The block SHALL have port swt_changed, output, 1 bit: a one-cycle pulse asserted on the cycle any swt bit changes.
REQ-007 The block SHALL have port changed_mask, output, 8 bits: one-cycle per-bit flags identifying which swt bits changed, with the same timing as swt_changed.

Function
REQ-008 Each swt_raw bit SHALL pass through a two-flop synchronizer (sync1, then sync2) before any other logic uses it.
REQ-009 Each bit SHALL own an independent counter of width ceil(log2(DEBOUNCE_CYCLES)) bits plus its stable register, which drives swt[i].
REQ-010 On a clock edge where sync2[i] equals swt[i], counter[i] SHALL load 0 (mismatch run broken, glitch discarded).
REQ-011 On a clock edge where sync2[i] differs from swt[i] and counter[i] is below DEBOUNCE_CYCLES-1, counter[i] SHALL increment by 1.
REQ-012 On a clock edge where sync2[i] differs from swt[i] and counter[i] equals DEBOUNCE_CYCLES-1:
  - swt[i] SHALL load sync2[i];
  - counter[i] SHALL load 0;
  - changed_mask[i] SHALL be 1 for the following cycle.
REQ-013 Latency: if swt_raw[i] changes before clock edge k and then holds, swt[i] SHALL update at edge k+DEBOUNCE_CYCLES+1 (DEBOUNCE_CYCLES+2 edges inclusive), and not earlier.
REQ-014 A swt_raw pulse producing fewer than DEBOUNCE_CYCLES consecutive mismatching edges at sync2 SHALL leave swt unchanged and SHALL NOT raise swt_changed.
REQ-015 Counters SHALL never wrap, because the saturation value DEBOUNCE_CYCLES-1 always triggers either an update or a clear.
REQ-016 changed_mask SHALL be registered, and SHALL be all-zero on every edge where no bit updates.
REQ-017 swt_changed SHALL equal the OR-reduction of changed_mask, with zero additional latency.
REQ-018 Bits that qualify on the same edge SHALL all update on that edge, and all of them SHALL be set together in a single changed_mask pulse.
REQ-019 A bit that returns to its stable value mid-count SHALL clear its counter (REQ-010); a later change SHALL restart the count from 0.
REQ-020 swt SHALL change only via REQ-012 and reset; it SHALL never reflect sync1 or sync2 combinationally.

Reset
REQ-021 While rst is 1, the block SHALL asynchronously hold the following at 0 regardless of clk:
  - sync1 and sync2;
  - all counters;
  - swt = 8'h00;
  - changed_mask = 8'h00;
  - swt_changed = 0.
REQ-022 On rst deassertion with swt_raw nonzero, the nonzero bits SHALL be treated as fresh mismatches and SHALL update after the REQ-013 latency, measured from the first post-reset edge.
REQ-023 rst asserted mid-count SHALL discard all partial counts; there SHALL be no pending update after reset.

Verification
REQ-024 Bench DEBOUNCE_CYCLES SHALL be 4; run the following directed scenarios:
  - Reset, then hold swt_raw=8'h00: swt=8'h00 and swt_changed=0 for 20 cycles.
  - swt_raw 8'h00 -> 8'h13 (X=3, Y=2, add) before edge 0, then held: swt=8'h00 through edge 4; swt=8'h13 after edge 5; swt_changed=1 and changed_mask=8'h13 for exactly one cycle.
  - From a stable swt=8'h13, a swt_raw[6] glitch high for 3 cycles, then low: swt stays 8'h13 and swt_changed never asserts.
  - From a stable swt=8'h13, a swt_raw[6] bounce of 1 cycle high, 1 low, then held high: swt=8'h53 appears exactly 5 edges after the final rising transition, with one pulse and changed_mask=8'h40.
  - swt_raw[0] and swt_raw[7] change on different edges 2 cycles apart: two separate one-cycle pulses 2 cycles apart, with masks 8'h01 then 8'h80.
  - rst asserted 2 edges into a qualifying count of swt_raw=8'h19, then released: swt=8'h00 immediately; swt=8'h19 6 edges after release.
